dm_port_arbiter: RTL

// Shares the single-port data memory (1-cycle synchronous read) between the pipeline MEM stage
// (CPU port) and a debug/loader port used by benches to preload and inspect data memory.

---
 rtl/dm_port_arbiter_if.sv | 48 ++++
 rtl/dm_port_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between the MEM stage, the debug/loader port and the data memory.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dm_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_valid;
  logic          dbg_ready;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares a single-port, 1-cycle-read data memory between the CPU MEM stage and a debug port.
// CPU has priority; a starvation guard forces a debug slot after STARVE_LIMIT denied cycles.
module dm_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic            clk,
  input  logic            rst,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic {ARB, FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state_q, state_d;
  owner_t        rd_owner_q, rd_owner_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          grant_cpu, grant_dbg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rd_owner_q <= OWN_NONE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Grant is gated by rst so every output drops the moment reset asserts.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (!rst) begin
      if (state_q == FORCE && bus.dbg_valid) grant_dbg = 1'b1;
      else if (bus.cpu_req)                  grant_cpu = 1'b1;
      else if (bus.dbg_valid)                grant_dbg = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (bus.dbg_valid && !grant_dbg)
      wait_cnt_d = (wait_cnt_q == LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ARB:     if (wait_cnt_d == LIMIT) state_d = FORCE;
      FORCE:   state_d = ARB;
      default: state_d = ARB;
    endcase

    rd_owner_d = OWN_NONE;
    if (grant_cpu && !bus.cpu_we)      rd_owner_d = OWN_CPU;
    else if (grant_dbg && !bus.dbg_we) rd_owner_d = OWN_DBG;
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    if (grant_cpu) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_be    = bus.cpu_we ? bus.cpu_be : 4'h0;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (grant_dbg) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dbg_we;
      bus.mem_be    = bus.dbg_we ? 4'hF : 4'h0;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~grant_cpu & ~rst;
  assign bus.dbg_ready  = grant_dbg;
  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign bus.dbg_rvalid = (rd_owner_q == OWN_DBG);
  assign bus.cpu_rdata  = (rd_owner_q == OWN_CPU) ? bus.mem_rdata : {DW{1'b0}};
  assign bus.dbg_rdata  = (rd_owner_q == OWN_DBG) ? bus.mem_rdata : {DW{1'b0}};

endmodule
